regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 83 ++++++++
 tb/tb_regfile_wb_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: shares the single register-file write port between
// requester 0 (ALU) and requester 1 (load). Requests use valid/ready
// handshakes; accepted writes reach the write port one cycle later.
module regfile_wb_arbiter #(
  parameter int N_REG_ADDR = 5,
  parameter int N_DATA     = 32,
  parameter int N_CNT      = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req0_valid,
  input  logic [N_REG_ADDR-1:0] req0_addr,
  input  logic [N_DATA-1:0]     req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [N_REG_ADDR-1:0] req1_addr,
  input  logic [N_DATA-1:0]     req1_data,
  output logic                  req1_ready,
  output logic                  rf_write_enable_3,
  output logic [N_REG_ADDR-1:0] rf_addr_3,
  output logic [N_DATA-1:0]     rf_write_data_3,
  output logic                  read_hold,
  output logic [N_CNT-1:0]      write_count
);

  // Requester that won the previous transfer; 1 after reset so that
  // requester 0 wins the first contention.
  logic                  last_grant;
  logic                  grant1;
  logic                  xfer;
  logic                  commit;
  logic [N_REG_ADDR-1:0] sel_addr;
  logic [N_DATA-1:0]     sel_data;

  // Grant selection, handshake and write-data mux; ready is gated by reset
  // so nothing is accepted while rstn is low.
  always_comb begin
    grant1     = req1_valid & (~req0_valid | ~last_grant);
    req0_ready = rstn & req0_valid & ~grant1;
    req1_ready = rstn & grant1;
    xfer       = req0_ready | req1_ready;
    sel_addr   = grant1 ? req1_addr : req0_addr;
    sel_data   = grant1 ? req1_data : req0_data;
    commit     = xfer & (sel_addr != '0);
  end

  // Remember who won the last completed transfer, including x0 transfers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_grant <= 1'b1;
    end else if (xfer) begin
      last_grant <= grant1;
    end
  end

  // Register the accepted write; x0 writes are accepted but never strobed,
  // and address/data hold their last committed values otherwise.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rf_write_enable_3 <= 1'b0;
      rf_addr_3         <= '0;
      rf_write_data_3   <= '0;
    end else begin
      rf_write_enable_3 <= commit;
      if (commit) begin
        rf_addr_3       <= sel_addr;
        rf_write_data_3 <= sel_data;
      end
    end
  end

  // Count committed writes, visible together with the strobe they belong to.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      write_count <= '0;
    end else if (commit) begin
      write_count <= write_count + N_CNT'(1);
    end
  end

  assign read_hold = rf_write_enable_3;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (counter narrowed to
// 4 bits so that wrap-around is reachable quickly).
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rstn;
  logic        req0_valid;
  logic [4:0]  req0_addr;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [4:0]  req1_addr;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic        we3;
  logic [4:0]  addr3;
  logic [31:0] data3;
  logic        read_hold;
  logic [3:0]  write_count;

  int checks;
  int failures;
  logic [3:0] exp_count;

  regfile_wb_arbiter #(.N_REG_ADDR(5), .N_DATA(32), .N_CNT(4)) dut (
    .clk(clk), .rstn(rstn),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .rf_write_enable_3(we3), .rf_addr_3(addr3), .rf_write_data_3(data3),
    .read_hold(read_hold), .write_count(write_count)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    idle_inputs();
    @(negedge clk);
    rstn = 1'b1;
    exp_count = 4'd0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 32'h1;
    req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 32'h2;
    #1;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      failures++; $display("FAIL reset_ready got %b%b expected 00", req0_ready, req1_ready);
    end
    checks++;
    if (we3 !== 1'b0 || read_hold !== 1'b0 || addr3 !== 5'd0 || data3 !== 32'd0) begin
      failures++; $display("FAIL reset_port got we=%b hold=%b addr=%0d data=%h expected zeros", we3, read_hold, addr3, data3);
    end
    checks++;
    if (write_count !== 4'd0) begin
      failures++; $display("FAIL reset_count got %0d expected 0", write_count);
    end
    idle_inputs();
    rstn = 1'b1;
    exp_count = 4'd0;
  endtask

  task automatic test_single();
    @(negedge clk);
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      failures++; $display("FAIL single_ready got %b%b expected 10", req0_ready, req1_ready);
    end
    @(negedge clk);
    idle_inputs();
    exp_count = exp_count + 4'd1;
    checks++;
    if (we3 !== 1'b1 || read_hold !== 1'b1 || addr3 !== 5'd5 || data3 !== 32'hDEADBEEF || write_count !== exp_count) begin
      failures++; $display("FAIL single_write got we=%b hold=%b addr=%0d data=%h cnt=%0d expected 1 1 5 deadbeef %0d",
                           we3, read_hold, addr3, data3, write_count, exp_count);
    end
    @(negedge clk);
    checks++;
    if (we3 !== 1'b0 || read_hold !== 1'b0 || addr3 !== 5'd5 || data3 !== 32'hDEADBEEF || write_count !== exp_count) begin
      failures++; $display("FAIL single_idle got we=%b hold=%b addr=%0d data=%h cnt=%0d expected 0 0 5 deadbeef %0d",
                           we3, read_hold, addr3, data3, write_count, exp_count);
    end
  endtask

  task automatic test_contention();
    do_reset();
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h11;
    req1_valid = 1'b1; req1_addr = 5'd3; req1_data = 32'h22;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      failures++; $display("FAIL contention_first got %b%b expected 10", req0_ready, req1_ready);
    end
    @(negedge clk);
    req0_valid = 1'b0; req0_data = 32'h55;
    #1;
    checks++;
    if (req1_ready !== 1'b1 || we3 !== 1'b1 || addr3 !== 5'd3 || data3 !== 32'h11) begin
      failures++; $display("FAIL contention_second got rdy1=%b we=%b addr=%0d data=%h expected 1 1 3 11", req1_ready, we3, addr3, data3);
    end
    @(negedge clk);
    idle_inputs();
    exp_count = exp_count + 4'd2;
    checks++;
    if (we3 !== 1'b1 || addr3 !== 5'd3 || data3 !== 32'h22 || write_count !== exp_count) begin
      failures++; $display("FAIL contention_last_wins got we=%b addr=%0d data=%h cnt=%0d expected 1 3 22 %0d", we3, addr3, data3, write_count, exp_count);
    end
  endtask

  // Both requesters continuously valid; last grant was requester 1.
  task automatic test_round_robin();
    logic        exp_g1;
    logic [4:0]  exp_a;
    logic [31:0] exp_d;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (we3 !== 1'b1 || addr3 !== exp_a || data3 !== exp_d) begin
          failures++; $display("FAIL rr_write%0d got we=%b addr=%0d data=%h expected 1 %0d %h", i - 1, we3, addr3, data3, exp_a, exp_d);
        end
      end
      if (i < 6) begin
        req0_valid = 1'b1; req0_addr = 5'(i + 1);  req0_data = 32'h100 + 32'(i);
        req1_valid = 1'b1; req1_addr = 5'(i + 16); req1_data = 32'h200 + 32'(i);
        exp_g1 = (i % 2) == 1;
        exp_a  = exp_g1 ? req1_addr : req0_addr;
        exp_d  = exp_g1 ? req1_data : req0_data;
        #1;
        checks++;
        if (req0_ready !== ~exp_g1 || req1_ready !== exp_g1) begin
          failures++; $display("FAIL rr_grant%0d got %b%b expected %b%b", i, req0_ready, req1_ready, ~exp_g1, exp_g1);
        end
      end else begin
        idle_inputs();
      end
    end
    exp_count = exp_count + 4'd6;
    checks++;
    if (write_count !== exp_count) begin
      failures++; $display("FAIL rr_count got %0d expected %0d", write_count, exp_count);
    end
  endtask

  task automatic test_x0();
    @(negedge clk);
    req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h99;
    @(negedge clk);
    exp_count = exp_count + 4'd1;
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'hFFFFFFFF;
    #1;
    checks++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      failures++; $display("FAIL x0_ready got %b%b expected 01", req0_ready, req1_ready);
    end
    @(negedge clk);
    checks++;
    if (we3 !== 1'b0 || read_hold !== 1'b0 || write_count !== exp_count) begin
      failures++; $display("FAIL x0_no_write got we=%b hold=%b cnt=%0d expected 0 0 %0d", we3, read_hold, write_count, exp_count);
    end
    req0_valid = 1'b1; req0_addr = 5'd10; req0_data = 32'hAA;
    req1_valid = 1'b1; req1_addr = 5'd11; req1_data = 32'hBB;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      failures++; $display("FAIL x0_toggle got %b%b expected 10", req0_ready, req1_ready);
    end
    @(negedge clk);
    idle_inputs();
    exp_count = exp_count + 4'd1;
    checks++;
    if (we3 !== 1'b1 || addr3 !== 5'd10 || data3 !== 32'hAA || write_count !== exp_count) begin
      failures++; $display("FAIL x0_after got we=%b addr=%0d data=%h cnt=%0d expected 1 10 aa %0d", we3, addr3, data3, write_count, exp_count);
    end
  endtask

  task automatic test_reset_mid();
    int strobes;
    @(negedge clk);
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h77;
    @(posedge clk);
    #2;
    idle_inputs();
    rstn = 1'b0;
    #1;
    checks++;
    if (we3 !== 1'b0 || read_hold !== 1'b0 || write_count !== 4'd0 || addr3 !== 5'd0) begin
      failures++; $display("FAIL midreset_clear got we=%b hold=%b cnt=%0d addr=%0d expected 0 0 0 0", we3, read_hold, write_count, addr3);
    end
    @(negedge clk);
    rstn = 1'b1;
    exp_count = 4'd0;
    strobes = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (we3 !== 1'b0 || addr3 === 5'd7) strobes++;
    end
    checks++;
    if (strobes !== 0 || write_count !== exp_count) begin
      failures++; $display("FAIL midreset_release got strobes=%0d cnt=%0d expected 0 %0d", strobes, write_count, exp_count);
    end
  endtask

  task automatic test_wrap();
    int stalls;
    stalls = 0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      req0_valid = 1'b1; req0_addr = 5'((i % 31) + 1); req0_data = 32'(i);
      #1;
      if (req0_ready !== 1'b1) stalls++;
    end
    @(negedge clk);
    idle_inputs();
    checks++;
    if (stalls !== 0 || write_count !== 4'd1) begin
      failures++; $display("FAIL wrap_count got stalls=%0d cnt=%0d expected 0 1", stalls, write_count);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    exp_count = 4'd0;
    idle_inputs();
    test_reset();
    test_single();
    test_contention();
    test_round_robin();
    test_x0();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
